// File: rtl/event_count_gen_if.sv
// Bus bundle for event_count_gen: control commands and raw event in,
// registered count / wrap / running out, plus an FSM state debug tap.
//
// Signalling: there is no valid/ready handshake on this bus. Every
// command input (start, stop, clear, load, up_dn, event_in, load_val) is
// a level sampled on each rising clk edge. Every output is registered
// and changes only on a rising clk edge.
interface event_count_gen_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up_dn;
    logic             event_in;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             running;
    logic [1:0]       state_dbg;

    // Driver side (testbench or upstream control logic).
    modport master (
        output start, stop, clear, load, load_val, up_dn, event_in,
        input  count, wrap, running, state_dbg
    );

    // Counter side.
    modport slave (
        input  start, stop, clear, load, load_val, up_dn, event_in,
        output count, wrap, running, state_dbg
    );
endinterface

// File: rtl/event_count_gen.sv
// Programmable modulo event counter. Rising edges on event_in are counted
// up or down while the run/pause FSM is in RUN. Clear and parallel load
// take priority over counting; a one-cycle wrap pulse marks each modulo
// wrap so the downstream overflow stage can cross-check itself.
module event_count_gen #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255
) (
    input  logic                clk,
    input  logic                reset,
    event_count_gen_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    // Terminal count at bus width; the counter runs modulo MAX_VAL+1.
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             event_q;
    logic             rise;

    // A level held high yields one rise; event_q follows event_in in
    // every state so resuming RUN never counts an already-high level.
    assign rise = bus.event_in & ~event_q;

    // Event history register, tracked regardless of FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_q <= 1'b0;
        end else begin
            event_q <= bus.event_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clear dominates, and stop beats a coincident start.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (bus.start && !bus.stop) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Count datapath: clear > load > counted edge; wrap only on a real wrap.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            // Out-of-range loads saturate at the terminal count.
            count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
        end else if ((state_q == ST_RUN) && rise) begin
            if (bus.up_dn) begin
                if (count_q == MAX_C) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE_C;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_C;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
        end
    end

    // Count and wrap registers; reset discards any count without a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Outputs come straight from registers; no input-to-output path.
    assign bus.count     = count_q;
    assign bus.wrap      = wrap_q;
    assign bus.running   = (state_q == ST_RUN);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_event_count_gen.sv
// Bench for event_count_gen: two instances (MAX_VAL 255 and 99) share one
// input stream; a modulo-arithmetic reference model predicts each one.
module tb_event_count_gen;

    localparam int W = 10;  // {wrap, running, count[7:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- stimulus variables ----------------
    logic       start, stop, clear, load, up_dn, event_in;
    logic [7:0] load_val;

    event_count_gen_if #(.WIDTH(8)) ifa ();
    event_count_gen_if #(.WIDTH(8)) ifb ();

    assign ifa.start = start;     assign ifb.start = start;
    assign ifa.stop = stop;       assign ifb.stop = stop;
    assign ifa.clear = clear;     assign ifb.clear = clear;
    assign ifa.load = load;       assign ifb.load = load;
    assign ifa.load_val = load_val; assign ifb.load_val = load_val;
    assign ifa.up_dn = up_dn;     assign ifb.up_dn = up_dn;
    assign ifa.event_in = event_in; assign ifb.event_in = event_in;

    event_count_gen #(.WIDTH(8), .MAX_VAL(255)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    event_count_gen #(.WIDTH(8), .MAX_VAL(99)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    logic [W-1:0] obs_a, obs_b;
    assign obs_a = {ifa.wrap, ifa.running, ifa.count};
    assign obs_b = {ifb.wrap, ifb.running, ifb.count};

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: state as 0 idle / 1 run / 2 paused, counts as ints.
    int m_st  = 0;
    int m_evq = 0;
    int m_cnt[2];
    int m_wrap[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the edge, then compare both DUTs.
    task automatic tick();
        int rise;
        int mx;
        logic [W-1:0] e;
        @(posedge clk);
        rise = (event_in && (m_evq == 0)) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            mx = (i == 0) ? 255 : 99;
            if (reset || clear) begin
                m_cnt[i] = 0; m_wrap[i] = 0;
            end else if (load) begin
                m_cnt[i] = (int'(load_val) > mx) ? mx : int'(load_val);
                m_wrap[i] = 0;
            end else if (m_st == 1 && rise == 1) begin
                if (up_dn) begin
                    m_wrap[i] = (m_cnt[i] == mx) ? 1 : 0;
                    m_cnt[i] = (m_cnt[i] + 1) % (mx + 1);
                end else begin
                    m_wrap[i] = (m_cnt[i] == 0) ? 1 : 0;
                    m_cnt[i] = (m_cnt[i] + mx) % (mx + 1);
                end
            end else begin
                m_wrap[i] = 0;
            end
        end
        if (reset || clear) m_st = 0;
        else if (stop) begin
            if (m_st == 1) m_st = 2;
        end else if (start) m_st = 1;
        m_evq = reset ? 0 : (event_in ? 1 : 0);
        for (int i = 0; i < 2; i++) begin
            e = {1'(m_wrap[i]), (m_st == 1), 8'(m_cnt[i])};
            exp_q.push_back(e);
        end
        #1;
        check("tick_a", 32'(obs_a), 32'(exp_q.pop_front()));
        check("tick_b", 32'(obs_b), 32'(exp_q.pop_front()));
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; clear = 0; load = 0; event_in = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        m_cnt[0] = 0; m_cnt[1] = 0; m_wrap[0] = 0; m_wrap[1] = 0;
        reset = 1; idle_inputs(); up_dn = 1; load_val = 8'h00;

        // Reset with event toggling
        event_in = 1; tick();
        event_in = 0; tick();
        check("rst_count", ifa.count, 0);
        check("rst_wrap", ifa.wrap, 0);
        check("rst_running", ifa.running, 0);
        reset = 0;
        event_in = 1; tick();
        event_in = 0; tick();
        check("idle_no_count", ifa.count, 0);

        // Basic up-count
        start = 1; tick(); start = 0;
        check("run_after_start", ifa.running, 1);
        for (int k = 1; k <= 3; k++) begin
            event_in = 1; tick();
            check("up_step", ifa.count, k);
            event_in = 0; tick(); tick();
        end
        event_in = 1; repeat (5) tick();
        event_in = 0; tick();
        check("level_once", ifa.count, 4);

        // Up wrap
        load = 1; load_val = 8'hFE; tick(); load = 0;
        check("load_fe", ifa.count, 8'hFE);
        check("load_clamp_b", ifb.count, 99);
        event_in = 1; tick();
        check("fe_ff", ifa.count, 8'hFF);
        check("no_wrap_fe_ff", ifa.wrap, 0);
        check("wrap_b_99_0", ifb.wrap, 1);
        event_in = 0; tick();
        event_in = 1; tick();
        check("ff_00", ifa.count, 0);
        check("wrap_ff_00", ifa.wrap, 1);
        event_in = 0; tick();
        check("wrap_one_cycle", ifa.wrap, 0);

        // Down count and down wrap
        load = 1; load_val = 8'hC8; tick(); load = 0;
        check("clamp_c8_b", ifb.count, 99);
        up_dn = 0; event_in = 1; tick();
        check("down_b", ifb.count, 98);
        check("down_a", ifa.count, 8'hC7);
        event_in = 0; clear = 1; tick(); clear = 0;
        check("clear_cnt", ifb.count, 0);
        check("clear_idle", ifb.running, 0);
        start = 1; tick(); start = 0;
        event_in = 1; tick();
        check("down_wrap_b", ifb.count, 99);
        check("down_wrap_b_flag", ifb.wrap, 1);
        check("down_wrap_a", ifa.count, 255);
        event_in = 0; tick();

        // Pause: start+stop together in RUN
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        check("paused", ifa.running, 0);
        event_in = 1; tick();
        check("paused_hold", ifb.count, 99);
        event_in = 0; start = 1; tick(); start = 0;
        check("resumed", ifa.running, 1);
        up_dn = 1; event_in = 1; tick();
        check("resume_count_a", ifa.count, 0);
        event_in = 0; tick();

        // clear + load + event together
        clear = 1; load = 1; load_val = 8'h55; event_in = 1; tick();
        idle_inputs();
        check("clr_prio_cnt", ifa.count, 0);
        check("clr_prio_idle", ifa.running, 0);
        tick();
        start = 1; tick(); start = 0;
        load = 1; load_val = 8'h30; event_in = 1; tick();
        check("load_no_inc", ifa.count, 8'h30);
        idle_inputs(); tick();

        // Reset mid-operation
        load = 1; load_val = 8'h40; tick(); load = 0;
        check("mid_load", ifa.count, 8'h40);
        reset = 1; event_in = 1; tick();
        check("mid_rst_cnt", ifa.count, 0);
        check("mid_rst_run", ifa.running, 0);
        check("mid_rst_wrap", ifa.wrap, 0);
        reset = 0; event_in = 0; tick();

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 99) < 2);
            clear    = ($urandom_range(0, 99) < 3);
            load     = ($urandom_range(0, 99) < 6);
            start    = ($urandom_range(0, 99) < 15);
            stop     = ($urandom_range(0, 99) < 6);
            event_in = 1'($urandom_range(0, 1));
            load_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) up_dn = ~up_dn;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
